// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MIPS MEM stage. Issues loads/stores on a req/ack data bus
//               with arbitrary wait states. Generates byte enables and store
//               replication, extracts and extends load data, and selects
//               write-back data. Stalls the pipeline while an access is
//               outstanding. Drives the registered MEM/WB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_lui_sig,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        mem_MemtoReg,
  input  logic        mem_RegWrite,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata_b,
  input  logic [5:0]  mem_opcode,
  input  logic [31:0] mem_imme_num,
  input  logic [4:0]  mem_wreg,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_addr_err,
  output logic [31:0] wb_badvaddr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        dbus_req_q, dbus_req_d;
  logic        dbus_we_q, dbus_we_d;
  logic [3:0]  dbus_be_q, dbus_be_d;
  logic [31:0] dbus_addr_q, dbus_addr_d;
  logic [31:0] dbus_wdata_q, dbus_wdata_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        wb_addr_err_q, wb_addr_err_d;
  logic [31:0] wb_badvaddr_q, wb_badvaddr_d;

  logic        w_acc;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_aligned_acc;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_ld_sext;
  logic [31:0] w_ld_data;
  logic [31:0] w_wb_data;
  logic        w_unused;

  // Opcode bits above the width/sign field and the upper immediate are not needed here
  assign w_unused = ^{mem_opcode[5:3], mem_imme_num[31:16]};

  // Classify the access: width from opcode[1:0], alignment from the low address bits
  always_comb begin
    w_acc         = mem_MemRead | mem_MemWrite;
    w_is_byte     = (mem_opcode[1:0] == 2'b00);
    w_is_half     = (mem_opcode[1:0] == 2'b01);
    w_is_word     = mem_opcode[1];
    w_misaligned  = w_acc & ((w_is_half & mem_alu_result[0]) |
                             (w_is_word & (mem_alu_result[1:0] != 2'b00)));
    w_aligned_acc = w_acc & ~w_misaligned;
  end

  // Store byte lanes and data replication; loads always enable all four lanes
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = mem_rdata_b;
    if (w_is_byte) begin
      w_st_wdata = {4{mem_rdata_b[7:0]}};
    end else if (w_is_half) begin
      w_st_wdata = {2{mem_rdata_b[15:0]}};
    end
    if (mem_MemWrite) begin
      if (w_is_byte) begin
        w_st_be = 4'b0001 << mem_alu_result[1:0];
      end else if (w_is_half) begin
        w_st_be = mem_alu_result[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  // Pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    case (mem_alu_result[1:0])
      2'b00:   w_ld_byte = dbus_rdata[7:0];
      2'b01:   w_ld_byte = dbus_rdata[15:8];
      2'b10:   w_ld_byte = dbus_rdata[23:16];
      default: w_ld_byte = dbus_rdata[31:24];
    endcase
    w_ld_half = mem_alu_result[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    w_ld_sext = ~mem_opcode[2];
    if (w_is_byte) begin
      w_ld_data = {{24{w_ld_sext & w_ld_byte[7]}}, w_ld_byte};
    end else if (w_is_half) begin
      w_ld_data = {{16{w_ld_sext & w_ld_half[15]}}, w_ld_half};
    end else begin
      w_ld_data = dbus_rdata;
    end
  end

  // Write-back source: load data, then LUI immediate, then ALU result
  always_comb begin
    if (mem_MemtoReg & mem_MemRead) begin
      w_wb_data = w_ld_data;
    end else if (mem_lui_sig) begin
      w_wb_data = {mem_imme_num[15:0], 16'h0000};
    end else begin
      w_wb_data = mem_alu_result;
    end
  end

  // Stall for every aligned access until the completing ack is seen in BUS
  assign mem_stall = w_aligned_acc & ~((state_q == ST_BUS) & dbus_ack);

  // Bus FSM: launch from IDLE, hold the request stable in BUS until ack
  always_comb begin
    state_d      = state_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_be_d    = dbus_be_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_wdata_d = dbus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (w_aligned_acc) begin
          dbus_req_d   = 1'b1;
          dbus_we_d    = mem_MemWrite;
          dbus_be_d    = w_st_be;
          dbus_addr_d  = {mem_alu_result[31:2], 2'b00};
          dbus_wdata_d = w_st_wdata;
          state_d      = ST_BUS;
        end
      end
      ST_BUS: begin
        if (dbus_ack) begin
          dbus_req_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        dbus_req_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // MEM/WB update: a bubble while stalled, otherwise capture this instruction
  always_comb begin
    wb_regwrite_d = 1'b0;
    wb_addr_err_d = 1'b0;
    wb_wreg_d     = wb_wreg_q;
    wb_wdata_d    = wb_wdata_q;
    wb_badvaddr_d = wb_badvaddr_q;
    if (!mem_stall) begin
      wb_regwrite_d = mem_RegWrite & ~w_misaligned;
      wb_addr_err_d = w_misaligned;
      wb_wreg_d     = mem_wreg;
      wb_wdata_d    = w_wb_data;
      if (w_misaligned) begin
        wb_badvaddr_d = mem_alu_result;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      dbus_req_q    <= 1'b0;
      dbus_we_q     <= 1'b0;
      dbus_be_q     <= 4'b0000;
      dbus_addr_q   <= 32'h0;
      dbus_wdata_q  <= 32'h0;
      wb_regwrite_q <= 1'b0;
      wb_wreg_q     <= 5'd0;
      wb_wdata_q    <= 32'h0;
      wb_addr_err_q <= 1'b0;
      wb_badvaddr_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      dbus_req_q    <= dbus_req_d;
      dbus_we_q     <= dbus_we_d;
      dbus_be_q     <= dbus_be_d;
      dbus_addr_q   <= dbus_addr_d;
      dbus_wdata_q  <= dbus_wdata_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_wreg_q     <= wb_wreg_d;
      wb_wdata_q    <= wb_wdata_d;
      wb_addr_err_q <= wb_addr_err_d;
      wb_badvaddr_q <= wb_badvaddr_d;
    end
  end

  assign dbus_req    = dbus_req_q;
  assign dbus_we     = dbus_we_q;
  assign dbus_be     = dbus_be_q;
  assign dbus_addr   = dbus_addr_q;
  assign dbus_wdata  = dbus_wdata_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_wreg     = wb_wreg_q;
  assign wb_wdata    = wb_wdata_q;
  assign wb_addr_err = wb_addr_err_q;
  assign wb_badvaddr = wb_badvaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access: directed vector table,
//               reset sequences and randomized instructions against a
//               behavioural model of the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        mem_lui_sig, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
  logic [31:0] mem_alu_result, mem_rdata_b, mem_imme_num;
  logic [5:0]  mem_opcode;
  logic [4:0]  mem_wreg;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        mem_stall, wb_RegWrite, wb_addr_err;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_wdata, wb_badvaddr;

  mem_access dut (
    .clk(clk), .rst(rst),
    .mem_lui_sig(mem_lui_sig), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_RegWrite(mem_RegWrite),
    .mem_alu_result(mem_alu_result), .mem_rdata_b(mem_rdata_b), .mem_opcode(mem_opcode),
    .mem_imme_num(mem_imme_num), .mem_wreg(mem_wreg),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .wb_RegWrite(wb_RegWrite), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .wb_addr_err(wb_addr_err), .wb_badvaddr(wb_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata_b;
    logic [31:0] imme;
    logic        lui, rd, wr, m2r, rw;
    logic [4:0]  wreg;
    int          waits;
    logic [31:0] bus_rdata;
  } instr_t;

  typedef struct {
    logic        acc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        rw;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  typedef struct {
    instr_t i;
    exp_t   e;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] rdata_b, input logic [31:0] imme,
                                input logic lui, input logic rd, input logic wr,
                                input logic m2r, input logic rw, input logic [4:0] wreg,
                                input int waits, input logic [31:0] bus_rdata);
    instr_t i;
    i.op = op; i.addr = addr; i.rdata_b = rdata_b; i.imme = imme;
    i.lui = lui; i.rd = rd; i.wr = wr; i.m2r = m2r; i.rw = rw;
    i.wreg = wreg; i.waits = waits; i.bus_rdata = bus_rdata;
    return i;
  endfunction

  function automatic exp_t mke(input logic acc, input logic we, input logic [3:0] be,
                               input logic [31:0] baddr, input logic [31:0] bwdata,
                               input logic rw, input logic [31:0] wdata, input logic err);
    exp_t e;
    e.acc = acc; e.we = we; e.be = be; e.baddr = baddr; e.bwdata = bwdata;
    e.rw = rw; e.wdata = wdata; e.err = err;
    return e;
  endfunction

  // Behavioural model: width in bytes, offset arithmetic, masks and multiplies
  function automatic exp_t model(input instr_t i);
    exp_t        e;
    int          n;
    int          off;
    logic [31:0] mask;
    logic [31:0] raw;
    logic        acc;
    logic        mis;
    n    = (i.op[1:0] == 2'b00) ? 1 : (i.op[1:0] == 2'b01) ? 2 : 4;
    off  = int'(i.addr[1:0]);
    acc  = i.rd | i.wr;
    mis  = acc && ((off % n) != 0);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    raw  = (i.bus_rdata >> (8 * off)) & mask;
    if (!i.op[2] && n < 4 && raw[8 * n - 1]) raw = raw | ~mask;
    e.err    = mis;
    e.acc    = acc & ~mis;
    e.we     = i.wr;
    e.be     = i.wr ? 4'(((1 << n) - 1) << off) : 4'hF;
    e.baddr  = i.addr - 32'(off);
    e.bwdata = (n == 1) ? 32'(i.rdata_b[7:0]) * 32'h0101_0101 :
               (n == 2) ? 32'(i.rdata_b[15:0]) * 32'h0001_0001 : i.rdata_b;
    e.rw     = i.rw & ~mis;
    e.wdata  = (i.m2r & i.rd) ? raw : i.lui ? (i.imme << 16) : i.addr;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      i;
    int          kind;
    logic [31:0] a;
    kind = $urandom_range(0, 2);
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    i = mk(6'(kind == 0 ? $urandom : 0), a, $urandom, $urandom, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 5'($urandom), $urandom_range(0, 3), $urandom);
    if (kind == 0) begin
      i.lui = 1'($urandom); i.m2r = 1'($urandom); i.rw = 1'b1;
    end else if (kind == 1) begin
      i.op = {3'b100, 1'($urandom), 2'($urandom)};
      i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.lui = 1'($urandom);
    end else begin
      i.op = {3'b101, 1'b0, 2'($urandom)};
      i.wr = 1'b1;
    end
    return i;
  endfunction

  task automatic drive(input instr_t i);
    mem_opcode = i.op; mem_alu_result = i.addr; mem_rdata_b = i.rdata_b;
    mem_imme_num = i.imme; mem_lui_sig = i.lui; mem_MemRead = i.rd;
    mem_MemWrite = i.wr; mem_MemtoReg = i.m2r; mem_RegWrite = i.rw; mem_wreg = i.wreg;
  endtask

  // Enters and leaves on a falling edge; EX/MEM inputs are held for the whole stall
  task automatic exec(input instr_t i, input exp_t e);
    drive(i);
    dbus_ack = 1'b0;
    if (e.acc) begin
      #1;
      check("stall_c0", 32'(mem_stall), 32'd1);
      check("req_c0", 32'(dbus_req), 32'd0);
      @(posedge clk); @(negedge clk);
      for (int w = 0; w <= i.waits; w++) begin
        if (w == i.waits) begin
          dbus_ack = 1'b1; dbus_rdata = i.bus_rdata;
        end else begin
          dbus_ack = 1'b0; dbus_rdata = $urandom;
        end
        #1;
        check("stall_bus", 32'(mem_stall), 32'(w != i.waits));
        check("req_bus", 32'(dbus_req), 32'd1);
        check("we_bus", 32'(dbus_we), 32'(e.we));
        check("be_bus", 32'(dbus_be), 32'(e.be));
        check("addr_bus", dbus_addr, e.baddr);
        if (e.we) check("wdata_bus", dbus_wdata, e.bwdata);
        check("wb_bubble", 32'(wb_RegWrite), 32'd0);
        @(posedge clk); @(negedge clk);
      end
      dbus_ack = 1'b0; dbus_rdata = $urandom;
      check("req_drop", 32'(dbus_req), 32'd0);
      check("wb_regwrite", 32'(wb_RegWrite), 32'(e.rw));
      check("wb_wreg", 32'(wb_wreg), 32'(i.wreg));
      check("wb_wdata", wb_wdata, e.wdata);
      check("wb_addr_err", 32'(wb_addr_err), 32'd0);
    end else begin
      dbus_ack = 1'($urandom); dbus_rdata = $urandom;
      #1;
      check("stall_none", 32'(mem_stall), 32'd0);
      check("req_none", 32'(dbus_req), 32'd0);
      @(posedge clk); @(negedge clk);
      dbus_ack = 1'b0;
      check("req_after", 32'(dbus_req), 32'd0);
      check("wb_regwrite", 32'(wb_RegWrite), 32'(e.rw));
      check("wb_addr_err", 32'(wb_addr_err), 32'(e.err));
      if (e.err) begin
        check("wb_badvaddr", wb_badvaddr, i.addr);
      end else begin
        check("wb_wreg", 32'(wb_wreg), 32'(i.wreg));
        check("wb_wdata", wb_wdata, e.wdata);
      end
    end
  endtask

  vec_t   vecs[$];
  instr_t idle;
  instr_t ri;

  initial begin
    idle = mk(6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0);

    //          op     addr          rdata_b       imme          lui rd wr m2r rw wreg waits bus_rdata
    vecs.push_back('{mk(6'h23, 32'h100, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd5, 0, 32'h8899AABB),
                     mke(1, 0, 4'hF, 32'h100, 32'h0, 1, 32'h8899AABB, 0)});
    vecs.push_back('{mk(6'h20, 32'h103, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd6, 1, 32'h80123456),
                     mke(1, 0, 4'hF, 32'h100, 32'h0, 1, 32'hFFFFFF80, 0)});
    vecs.push_back('{mk(6'h24, 32'h103, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd6, 0, 32'h80123456),
                     mke(1, 0, 4'hF, 32'h100, 32'h0, 1, 32'h00000080, 0)});
    vecs.push_back('{mk(6'h29, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 1, 0, 0, 5'd0, 3, 32'h0),
                     mke(1, 1, 4'hC, 32'h100, 32'hABCDABCD, 0, 32'h102, 0)});
    vecs.push_back('{mk(6'h23, 32'h101, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd8, 0, 32'h0),
                     mke(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1)});
    vecs.push_back('{mk(6'h0F, 32'h12345678, 32'h0, 32'h0000BEEF, 1, 0, 0, 0, 1, 5'd9, 0, 32'h0),
                     mke(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hBEEF0000, 0)});
    vecs.push_back('{mk(6'h21, 32'h102, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd10, 2, 32'h80017FFF),
                     mke(1, 0, 4'hF, 32'h100, 32'h0, 1, 32'hFFFF8001, 0)});
    vecs.push_back('{mk(6'h25, 32'h100, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd11, 0, 32'h8001F00D),
                     mke(1, 0, 4'hF, 32'h100, 32'h0, 1, 32'h0000F00D, 0)});
    vecs.push_back('{mk(6'h28, 32'h101, 32'h000000A5, 32'h0, 0, 0, 1, 0, 0, 5'd0, 1, 32'h0),
                     mke(1, 1, 4'h2, 32'h100, 32'hA5A5A5A5, 0, 32'h101, 0)});
    vecs.push_back('{mk(6'h28, 32'h103, 32'h0000005A, 32'h0, 0, 0, 1, 0, 0, 5'd0, 0, 32'h0),
                     mke(1, 1, 4'h8, 32'h100, 32'h5A5A5A5A, 0, 32'h103, 0)});
    vecs.push_back('{mk(6'h2B, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 1, 0, 0, 5'd0, 2, 32'h0),
                     mke(1, 1, 4'hF, 32'h104, 32'hDEADBEEF, 0, 32'h104, 0)});
    vecs.push_back('{mk(6'h29, 32'h103, 32'h11112222, 32'h0, 0, 0, 1, 0, 0, 5'd0, 0, 32'h0),
                     mke(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1)});
    vecs.push_back('{mk(6'h00, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 0, 0, 1, 5'd7, 0, 32'h0),
                     mke(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hCAFEF00D, 0)});
    vecs.push_back('{mk(6'h22, 32'h108, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd12, 0, 32'h01020304),
                     mke(1, 0, 4'hF, 32'h108, 32'h0, 1, 32'h01020304, 0)});

    // Reset held for two cycles with an idle instruction
    rst = 1'b0;
    drive(idle);
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dbus_req), 32'd0);
    check("rst_we", 32'(dbus_we), 32'd0);
    check("rst_be", 32'(dbus_be), 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wb_rw", 32'(wb_RegWrite), 32'd0);
    check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_wb_err", 32'(wb_addr_err), 32'd0);
    check("rst_wb_bad", wb_badvaddr, 32'd0);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) exec(vecs[k].i, vecs[k].e);

    // Reset lands during a BUS wait state; the late ack must be ignored
    drive(mk(6'h23, 32'h200, 32'h0, 32'h0, 0, 1, 0, 1, 1, 5'd3, 0, 32'h0));
    dbus_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstmid_req_up", 32'(dbus_req), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(idle);
    @(posedge clk); @(negedge clk);
    check("rstmid_req", 32'(dbus_req), 32'd0);
    check("rstmid_wb_rw", 32'(wb_RegWrite), 32'd0);
    rst = 1'b1;
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    dbus_ack = 1'b0;
    check("lateack_req", 32'(dbus_req), 32'd0);
    check("lateack_stall", 32'(mem_stall), 32'd0);
    check("lateack_wb_rw", 32'(wb_RegWrite), 32'd0);
    check("lateack_wb_wdata", wb_wdata, 32'd0);
    exec(vecs[0].i, vecs[0].e);

    // Randomized instruction stream against the model
    for (int k = 0; k < 300; k++) begin
      ri = rand_instr();
      exec(ri, model(ri));
    end

    drive(idle);
    @(posedge clk); @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the five-stage MIPS pipeline. Consumes the MEM-side signals registered by the EX/MEM pipeline register and performs loads and stores over a req/ack data bus with arbitrary wait states. Generates byte enables and store-data replication, extracts and extends load data, and selects the write-back value. Asserts a pipeline stall while an access is outstanding and drives the registered MEM/WB outputs consumed by the register-file write port.

## Interface
Parameters: none.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- mem_lui_sig, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite  in  1 each  control from EX/MEM register
- mem_alu_result  in  32  effective address, or ALU result
- mem_rdata_b  in  32  store source register value
- mem_opcode  in  6  instruction opcode; selects width and sign
- mem_imme_num  in  32  immediate; low 16 bits used by LUI
- mem_wreg  in  5  destination register
- dbus_req  out  1  access request, registered
- dbus_we  out  1  1 = store
- dbus_be  out  4  byte enables
- dbus_addr  out  32  word-aligned address
- dbus_wdata  out  32  store data
- dbus_ack  in  1  single-cycle completion
- dbus_rdata  in  32  load data, valid with ack
- mem_stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- wb_RegWrite  out  1  registered write enable
- wb_wreg  out  5  registered destination
- wb_wdata  out  32  registered write-back data
- wb_addr_err  out  1  registered misaligned-access flag, one cycle
- wb_badvaddr  out  32  registered faulting address

## Operation
- acc = mem_MemRead | mem_MemWrite. Width comes from mem_opcode[1:0]: 00 = byte, 01 = half, 11 = word, 10 = word. Load sign comes from mem_opcode[2]: 0 = sign-extend, 1 = zero-extend.
- Alignment:
  - A half access is misaligned when addr[0] = 1.
  - A word access is misaligned when addr[1:0] ≠ 0.
  - A misaligned access:
    - issues no bus cycle and does not stall;
    - sets wb_addr_err = 1 and wb_badvaddr = addr;
    - sets wb_RegWrite = 0.
- Store enables and data:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{rdata_b[7:0]}}
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{rdata_b[15:0]}}
  - word: be = 1111; wdata = rdata_b
  - Loads drive be = 1111.
- dbus_addr = {addr[31:2], 2'b00}.
- Load extraction: select the byte or half from dbus_rdata using addr[1:0] or addr[1], then extend per sign.
- Write-back data selection, in priority order:
  1. MemtoReg & MemRead → extracted load data
  2. lui_sig → {imme_num[15:0], 16'h0}
  3. otherwise → alu_result
- FSM has two states, IDLE and BUS:
  - IDLE: if acc is set and the address is aligned, load dbus_* and set dbus_req = 1, then go to BUS. Otherwise stay in IDLE. dbus_ack is ignored in IDLE.
  - BUS: hold dbus_req, dbus_we, dbus_be, dbus_addr and dbus_wdata stable. When dbus_ack = 1, capture the result into the wb_* registers, set dbus_req = 0 and go to IDLE.
- mem_stall = acc & aligned & ~(state == BUS & dbus_ack).
- wb_* update on every edge:
  - stalled: wb_RegWrite = 0 (bubble) and wb_addr_err = 0;
  - otherwise: wb_RegWrite = mem_RegWrite & ~misaligned, and wb_wreg and wb_wdata are loaded.

## Timing
- Reset: state = IDLE. dbus_req, dbus_we, dbus_be, dbus_addr and dbus_wdata are all 0. wb_RegWrite, wb_wreg, wb_wdata, wb_addr_err and wb_badvaddr are all 0.
- Non-memory instruction: 1 cycle in MEM; wb_* valid the following cycle.
- Memory access with ack in the first BUS cycle:
  - cycle 0: IDLE, stall = 1
  - cycle 1: req = 1, stall = 0
  - wb_* valid in cycle 2
  - Each additional wait state adds one cycle.
- Back-to-back accesses: FSM returns to IDLE and req drops for at least one cycle between accesses.
- Reset asserted mid-access: FSM goes to IDLE and req = 0 at that edge. A late ack is ignored.
- dbus_ack while req = 0: no effect.

## Test plan
- Reset: hold rst = 0 for 2 cycles → all outputs 0; mem_stall = 0 with acc = 0.
- LW at addr 0x100 with ack in the first BUS cycle, rdata 0x8899AABB → dbus_addr = 0x100, be = 1111; wb_wdata = 0x8899AABB two cycles after entry; stall high exactly 1 cycle.
- LB and LBU at 0x103 with rdata 0x80xxxxxx:
  - LB → wb_wdata = 0xFFFFFF80
  - LBU → wb_wdata = 0x00000080
- SH at 0x102 with rdata_b 0x1234ABCD and 3 wait states → be = 1100, wdata = 0xABCDABCD; req is stable for 4 cycles; stall is high 4 cycles; wb_RegWrite = 0.
- LW at 0x101 → no req; wb_addr_err = 1 and wb_badvaddr = 0x101; wb_RegWrite = 0; no stall.
- LUI with imme 0x0000BEEF → wb_wdata = 0xBEEF0000.
- Reset asserted during a BUS wait state, then ack arrives → req = 0 and state = IDLE; no wb update.
